// File: rtl/bcd_seg_scan_pkg.sv
// Shared constants for the BCD 7-segment scanner: active-low segment patterns
// ({g,f,e,d,c,b,a}) and the number of display positions.
package bcd_seg_scan_pkg;

  localparam int N_POS = 6;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD-to-7-segment decoder (active-low). Codes 10..15 show a dash;
// blank overrides everything.
module seg7_decode
  import bcd_seg_scan_pkg::*;
(
  input  logic [3:0] code,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    // NOTE: seg gets a default before any branch so no path leaves it unassigned (no latch).
    seg = SEG_DASH;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (code)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/bcd_seg_scan.sv
// Six-position multiplexed common-anode display driver with frame snapshots,
// leading-zero blanking and registered anode/segment outputs.
module bcd_seg_scan
  import bcd_seg_scan_pkg::*;
#(
  parameter int CLK_DIV = 100000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       x0,
  input  logic [3:0] x1,
  input  logic [3:0] x2,
  input  logic [3:0] x3,
  input  logic [3:0] x4,
  input  logic [3:0] x5,
  input  logic       blank_en,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int              PW        = $clog2(CLK_DIV);
  localparam logic [PW-1:0]   PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [2:0]      IDX_LAST  = 3'(N_POS - 1);

  logic [PW-1:0]         presc;
  logic [2:0]            idx;
  logic                  tick;
  logic                  load;
  logic                  load_pend;
  logic                  sh_x0;
  logic [4:0][3:0]       sh_dig;     // [0] = units (x5) ... [4] = x1
  logic [N_POS-1:0][3:0] pos_dig;
  logic [N_POS-1:0]      lz;
  logic                  blank;
  logic [6:0]            dec_seg;

  assign tick    = (presc == PRESC_MAX);
  assign load    = load_pend || (tick && (idx == IDX_LAST));
  assign pos_dig = {{3'b000, sh_x0}, sh_dig};
  assign dp      = 1'b1;

  // NOTE: async active-high reset in the sensitivity list; all state uses <= so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      presc     <= '0;
      idx       <= '0;
      load_pend <= 1'b1;
    end else begin
      presc     <= tick ? '0 : presc + 1'b1;
      load_pend <= 1'b0;
      if (tick) idx <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
    end
  end

  // Shadow is reset too so the first frame after reset never shows stale data.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sh_x0  <= 1'b0;
      sh_dig <= '0;
    end else if (load) begin
      sh_x0  <= x0;
      sh_dig <= {x1, x2, x3, x4, x5};
    end
  end

  // lz[k]: position k and everything above it are zero; units is never blanked.
  always_comb begin
    lz          = '0;
    lz[N_POS-1] = (pos_dig[N_POS-1] == 4'd0);
    for (int k = N_POS - 2; k >= 1; k--) begin
      lz[k] = lz[k+1] && (pos_dig[k] == 4'd0);
    end
  end

  assign blank = blank_en && lz[idx];

  seg7_decode u_dec (
    .code  (pos_dig[idx]),
    .blank (blank),
    .seg   (dec_seg)
  );

  // Outputs stay dark on the snapshot edge that follows reset.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      an  <= 6'h3F;
      seg <= SEG_BLANK;
    end else if (!load_pend) begin
      an  <= ~(6'b000001 << idx);
      seg <= dec_seg;
    end
  end

endmodule

// File: doc/bcd_seg_scan.md
Name: bcd_seg_scan

Overview:
Display stage directly downstream of the binary-to-BCD converter. Consumes its overflow bit plus five BCD digits. Time-multiplexes them onto a six-position common-anode 7-segment display with leading-zero blanking, invalid-digit indication and tear-free frame snapshots. Outputs drive the board anode/segment pins directly.

Parameters:
CLK_DIV, 100000, clk cycles each position stays lit (1 kHz per position at 100 MHz); legal range 2..2^20.

Ports:
clk       input   1   system clock, rising edge
clr       input   1   reset; asynchronous, active-high
x0        input   1   converter overflow bit (hundred-thousands place, value 0/1)
x1        input   4   BCD digit, 10^4 place
x2        input   4   BCD digit, 10^3 place
x3        input   4   BCD digit, 10^2 place
x4        input   4   BCD digit, 10^1 place
x5        input   4   BCD digit, 10^0 place
blank_en  input   1   1 = suppress leading zeros
an        output  6   anode enables, active-low; an[0] = units position, an[5] = overflow position
seg       output  7   segments {g,f,e,d,c,b,a}, active-low
dp        output  1   decimal point, active-low, held 1 (off)

Behaviour:
- Reset (clr=1, takes effect without a clock edge): an=6'h3F, seg=7'h7F, dp=1, prescaler=0, position index idx=0, shadow digits=0, load_pend=1.
- Prescaler counts 0..CLK_DIV-1 and wraps. tick = (prescaler==CLK_DIV-1).
- On tick, idx advances 0→1→…→5→0. A frame is 6*CLK_DIV cycles.
- Snapshot: the shadow register {x0,x1..x5} loads on the edge where (tick && idx==5), or on any edge with load_pend=1.
  - load_pend clears on its first load.
  - The first post-reset edge therefore captures the inputs.
  - Input changes mid-frame have no effect until the next frame boundary.
- Outputs are registered, with one cycle of latency from idx/shadow to pins.
  - an = ~(6'b1 << idx); exactly one bit is low at all times outside reset.
  - seg is the decoded pattern for the shadow value at idx.
- Position mapping: idx0=x5, idx1=x4, idx2=x3, idx3=x2, idx4=x1, idx5=x0 (shown as digit 0 or 1).
- Decode table (hex, active-low):
  - digits: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10
  - codes 10..15 = 3F (dash)
  - blank = 7F
- Leading-zero blanking, when blank_en=1:
  - Position k>0 is blank iff its digit and every higher position's digit are 0.
  - Position 0 is never blanked.
  - The anode still pulses for blanked positions; only seg=7F.
  - An invalid code (10..15) counts as non-zero.
- blank_en=0: all positions show their digit, so position 5 shows 0 or 1.
- blank_en is sampled live each cycle and is not snapshotted.
- Reset mid-frame: outputs go dark immediately. After release, the scan restarts at idx0 with a fresh snapshot.

Decomposition:
- Shared package: SEG_* 7-bit constants (digits 0–9, SEG_DASH=7'h3F, SEG_BLANK=7'h7F) and N_POS=6.
- One combinational sub-module, seg7_decode (4-bit code + blank → 7-bit seg), instantiated once on the muxed digit.
- Prescaler, index, snapshot and blanking logic stay in bcd_seg_scan.

Test Plan:
All scenarios use CLK_DIV=4.
1. Reset: assert clr asynchronously mid-cycle → an=3F, seg=7F, dp=1 with no clock edge. After release, the next edge snapshots and the following edge drives an=3E.
2. Blanking on: x0=0, digits 0,0,0,4,2, blank_en=1 → per frame:
   - idx0: an=3E, seg=24
   - idx1: an=3D, seg=19
   - idx2..idx5: seg=7F
   - each position lit exactly 4 cycles.
3. Blanking off, overflow: x0=1, all digits 0, blank_en=0 → idx5 seg=79, idx0..idx4 seg=40. Repeat with x0=0 → idx5 seg=40.
4. Snapshot: load 12345, then change to 99999 while idx=2 → the remainder of the frame still shows 12345. After the idx5→idx0 wrap, idx0 shows seg=10.
5. Invalid code: x3=4'hC, others 0, blank_en=1 → idx2 seg=3F. Positions above it are blank; idx1 and idx0 show 40, because the dash counts as non-zero.
6. Wrap count: run 3 frames → an sequence 3E,3D,3B,37,2F,1F repeats with no gap cycles and never two anodes low at once.
